// File: rtl/instruction_memory.sv
// Instruction memory for the MIPS fetch stage: byte-wise big-endian image load over a
// valid/ready port, ended by the HALT word. Optional build macro: IMEM_ALIGN_CHECK_EN.

`ifndef ADDRWIDTH
`define ADDRWIDTH 32
`endif

// state  | meaning
// IDLE   | after reset, waiting for load_start_i
// LOAD   | accepting image bytes, assembling and writing words
// READY  | image complete, serving fetches
module instruction_memory #(
    parameter int NB_ADDR  = `ADDRWIDTH,
    parameter int NB_INSTR = 32,
    parameter int DEPTH    = 256
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                load_start_i,
    input  logic                load_valid_i,
    input  logic [7:0]          load_byte_i,
    output logic                load_ready_o,
    output logic                load_done_o,
    output logic                overflow_o,
    input  logic                fetch_en_i,
    input  logic [NB_ADDR-1:0]  addr_i,
    output logic [NB_INSTR-1:0] instr_o,
    output logic                instr_valid_o,
    output logic                fault_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [NB_INSTR-1:0] HALT_WORD = '1;
    localparam logic [AW-1:0]       LAST_PTR  = AW'(DEPTH - 1);
    // One extra bit so the limit still fits when 4*DEPTH equals 2**NB_ADDR.
    localparam logic [NB_ADDR:0]    ADDR_LIMIT = (NB_ADDR + 1)'(4 * DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_READY
    } state_t;

    state_t state_q, state_d;

    logic [1:0]           byte_cnt_q, byte_cnt_d;
    logic [AW-1:0]        ptr_q, ptr_d;
    logic [NB_INSTR-9:0]  asm_q, asm_d;
    logic                 overflow_d;
    logic [NB_INSTR-1:0]  instr_d;
    logic                 fault_d;
    logic                 instr_valid_d;
    logic                 mem_we;

    logic [NB_INSTR-1:0]  mem [DEPTH];
    logic [NB_INSTR-1:0]  word_full;
    logic [AW-1:0]        fetch_idx;
    logic                 fetch_bad;

    assign word_full = {asm_q, load_byte_i};
    assign fetch_idx = addr_i[AW+1:2];

`ifdef IMEM_ALIGN_CHECK_EN
    assign fetch_bad = ({1'b0, addr_i} >= ADDR_LIMIT) || (addr_i[1:0] != 2'b00);
`else
    assign fetch_bad = ({1'b0, addr_i} >= ADDR_LIMIT);
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr_i[1:0];
`endif

    assign load_ready_o = (state_q == S_LOAD);
    assign load_done_o  = (state_q == S_READY);

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        ptr_d         = ptr_q;
        asm_d         = asm_q;
        overflow_d    = overflow_o;
        instr_d       = instr_o;
        fault_d       = fault_o;
        instr_valid_d = 1'b0;
        mem_we        = 1'b0;

        case (state_q)
            S_LOAD: begin
                if (load_valid_i) begin
                    if (byte_cnt_q == 2'd3) begin
                        mem_we     = 1'b1;
                        ptr_d      = ptr_q + 1'b1;
                        byte_cnt_d = 2'd0;
                        asm_d      = '0;
                        if (word_full == HALT_WORD) begin
                            state_d = S_READY;
                        end else if (ptr_q == LAST_PTR) begin
                            state_d    = S_READY;
                            overflow_d = 1'b1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        asm_d      = {asm_q[NB_INSTR-17:0], load_byte_i};
                    end
                end
            end
            S_READY: begin
                if (fetch_en_i) begin
                    instr_valid_d = 1'b1;
                    if (fetch_bad) begin
                        instr_d = '0;
                        fault_d = 1'b1;
                    end else begin
                        instr_d = mem[fetch_idx];
                        fault_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase

        // A restart wins over any byte presented in the same cycle.
        if (load_start_i) begin
            state_d    = S_LOAD;
            byte_cnt_d = 2'd0;
            ptr_d      = '0;
            asm_d      = '0;
            overflow_d = 1'b0;
            mem_we     = 1'b0;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            byte_cnt_q    <= 2'd0;
            ptr_q         <= '0;
            asm_q         <= '0;
            overflow_o    <= 1'b0;
            instr_o       <= '0;
            fault_o       <= 1'b0;
            instr_valid_o <= 1'b0;
        end else begin
            byte_cnt_q    <= byte_cnt_d;
            ptr_q         <= ptr_d;
            asm_q         <= asm_d;
            overflow_o    <= overflow_d;
            instr_o       <= instr_d;
            fault_o       <= fault_d;
            instr_valid_o <= instr_valid_d;
        end
    end

    // Program image survives reset; only control state is cleared.
    always_ff @(posedge clock_i) begin
        if (mem_we) begin
            mem[ptr_q] <= word_full;
        end
    end

endmodule

// File: tb/tb_instruction_memory.sv
// Scoreboard bench for instruction_memory: randomized loads and fetches against a
// word-array reference model; a monitor pops expectations whenever instr_valid_o is high.
module tb_instruction_memory;

    localparam int DEPTH = 256;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [7:0]  load_byte = 8'h00;
    logic        load_ready;
    logic        load_done;
    logic        overflow;
    logic        fetch_en = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fault;

    int errors = 0;
    int checks = 0;

    // Reference model: word array plus load progress expressed as byte list / word count.
    logic [31:0] ref_mem [DEPTH];
    logic [7:0]  m_bytes [$];
    int          m_nwords = 0;
    int          maxw = -1;
    bit          m_loading = 0;
    bit          m_ready = 0;
    bit          m_ovf = 0;

    logic [32:0] sb [$];

    instruction_memory dut (
        .clock_i      (clk),
        .reset_i      (rst_n),
        .load_start_i (load_start),
        .load_valid_i (load_valid),
        .load_byte_i  (load_byte),
        .load_ready_o (load_ready),
        .load_done_o  (load_done),
        .overflow_o   (overflow),
        .fetch_en_i   (fetch_en),
        .addr_i       (addr),
        .instr_o      (instr),
        .instr_valid_o(instr_valid),
        .fault_o      (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] exp_fetch(input logic [31:0] a);
        bit bad;
        bad = (a >= 32'(4 * DEPTH));
`ifdef IMEM_ALIGN_CHECK_EN
        if (a % 4 != 0) bad = 1;
`endif
        if (bad) return {1'b1, 32'h0};
        return {1'b0, ref_mem[a / 4]};
    endfunction

    // One clock of stimulus, applied at the negedge; the model advances alongside.
    task automatic cycle(input bit st, input bit v, input logic [7:0] b,
                         input bit fe, input logic [31:0] a);
        @(negedge clk);
        load_start = st;
        load_valid = v;
        load_byte  = b;
        fetch_en   = fe;
        addr       = a;
        if (fe && m_ready) sb.push_back(exp_fetch(a));
        if (st) begin
            m_loading = 1; m_ready = 0; m_ovf = 0; m_nwords = 0;
            m_bytes.delete();
        end else if (v && m_loading) begin
            m_bytes.push_back(b);
            if (m_bytes.size() == 4) begin
                logic [31:0] w;
                w = (32'(m_bytes[0]) << 24) + (32'(m_bytes[1]) << 16)
                  + (32'(m_bytes[2]) << 8) + 32'(m_bytes[3]);
                m_bytes.delete();
                ref_mem[m_nwords] = w;
                if (m_nwords > maxw) maxw = m_nwords;
                if (w == HALT) begin
                    m_loading = 0; m_ready = 1;
                end else if (m_nwords == DEPTH - 1) begin
                    m_loading = 0; m_ready = 1; m_ovf = 1;
                end
                m_nwords++;
            end
        end
    endtask

    task automatic idle();
        cycle(0, 0, 8'h00, 0, 32'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        int idx;
        r = $urandom_range(0, 9);
        idx = (maxw < 0) ? 0 : $urandom_range(0, maxw);
        if (r == 0) return $urandom | 32'h0000_0400;
        if (r == 1) return 32'(idx * 4 + $urandom_range(1, 3));
        return 32'(idx * 4);
    endfunction

    task automatic load_prog(input logic [31:0] words[$], input bit rnd);
        cycle(1, 0, 8'h00, 0, 32'h0);
        foreach (words[i]) begin
            for (int k = 3; k >= 0; k--) begin
                logic [31:0] w;
                w = words[i];
                while (rnd && $urandom_range(0, 3) == 0)
                    cycle(0, 0, 8'h00, $urandom_range(0, 1), rand_addr());
                cycle(0, 1, w[k*8 +: 8], rnd && ($urandom_range(0, 3) == 0), rand_addr());
            end
        end
    endtask

    task automatic check_status(input string tag);
        idle();
        @(posedge clk); #1;
        chk({tag, "_load_done"}, 32'(load_done), 32'(m_ready));
        chk({tag, "_overflow"},  32'(overflow),  32'(m_ovf));
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin : monitor
        logic [32:0] e;
        forever begin
            @(posedge clk); #1;
            if (instr_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_valid: got instr %h fault %b expected no fetch", instr, fault);
                end else begin
                    e = sb.pop_front();
                    chk("fetch_instr", instr, e[31:0]);
                    chk("fetch_fault", 32'(fault), 32'(e[32]));
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] prog [$];
        repeat (3) @(posedge clk);
        #1;
        chk("rst_load_ready", 32'(load_ready), 32'd0);
        chk("rst_load_done",  32'(load_done),  32'd0);
        chk("rst_overflow",   32'(overflow),   32'd0);
        chk("rst_instr",      instr,           32'd0);
        chk("rst_valid",      32'(instr_valid), 32'd0);
        chk("rst_fault",      32'(fault),      32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Basic program, with fetch requested while loading.
        cycle(1, 0, 8'h00, 0, 32'h0);
        cycle(0, 1, 8'h20, 1, 32'h0);
        @(posedge clk); #1;
        chk("load_fetch_valid", 32'(instr_valid), 32'd0);
        chk("load_fetch_instr", instr, 32'd0);
        chk("load_ready_in_load", 32'(load_ready), 32'd1);
        cycle(0, 1, 8'h08, 1, 32'h4);
        cycle(0, 1, 8'h00, 0, 32'h0);
        cycle(0, 1, 8'h05, 0, 32'h0);
        for (int k = 0; k < 4; k++) cycle(0, 1, 8'hFF, 0, 32'h0);
        check_status("basic");
        chk("basic_ref_word0", ref_mem[0], 32'h2008_0005);
        cycle(0, 0, 8'h00, 1, 32'h0);
        cycle(0, 0, 8'h00, 1, 32'h4);
        cycle(0, 0, 8'h00, 1, 32'd1024);
        cycle(0, 0, 8'h00, 1, 32'h0);
        cycle(0, 0, 8'h00, 1, 32'h2);
        cycle(0, 0, 8'h00, 1, 32'hFFFF_FFFC);
        idle();
        drain();

        // Overflow: DEPTH words with no HALT.
        prog.delete();
        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] w;
            w = $urandom;
            if (w == HALT) w = 32'h0;
            prog.push_back(w);
        end
        load_prog(prog, 0);
        check_status("ovf");
        chk("ovf_expected", 32'(m_ovf), 32'd1);
        cycle(0, 0, 8'h00, 1, 32'd1020);
        cycle(0, 0, 8'h00, 1, 32'd0);
        cycle(0, 0, 8'h00, 1, 32'd1024);
        cycle(0, 0, 8'h00, 1, 32'd512);
        idle();
        drain();

        // Restart mid-word; a byte coinciding with load_start is dropped.
        cycle(1, 0, 8'h00, 0, 32'h0);
        cycle(0, 1, 8'hAA, 0, 32'h0);
        cycle(0, 1, 8'hBB, 0, 32'h0);
        cycle(1, 1, 8'hCC, 0, 32'h0);
        for (int k = 0; k < 4; k++) cycle(0, 1, 8'h00, 0, 32'h0);
        for (int k = 0; k < 4; k++) cycle(0, 1, 8'hFF, 0, 32'h0);
        check_status("restart");
        cycle(0, 0, 8'h00, 1, 32'h0);
        cycle(0, 0, 8'h00, 1, 32'h4);
        idle();
        drain();

        // Randomized programs, gaps and fetches.
        for (int it = 0; it < 6; it++) begin
            int len;
            len = $urandom_range(1, 30);
            prog.delete();
            for (int i = 0; i < len; i++) begin
                logic [31:0] w;
                w = $urandom;
                if (w == HALT) w = 32'h1;
                prog.push_back(w);
            end
            prog.push_back(HALT);
            load_prog(prog, 1);
            check_status("rand");
            for (int f = 0; f < 30; f++)
                cycle(0, 0, 8'h00, $urandom_range(0, 3) != 0, rand_addr());
            idle();
            drain();
        end

        // Asynchronous reset in the middle of a load.
        prog.delete();
        prog.push_back(32'h1234_5678);
        prog.push_back(HALT);
        load_prog(prog, 0);
        cycle(0, 0, 8'h00, 1, 32'h0);
        idle();
        drain();
        cycle(1, 0, 8'h00, 0, 32'h0);
        for (int k = 0; k < 6; k++) cycle(0, 1, 8'(8'h40 + k), 0, 32'h0);
        @(negedge clk); #2;
        rst_n = 1'b0;
        load_start = 0; load_valid = 0; fetch_en = 0;
        m_loading = 0; m_ready = 0; m_ovf = 0; m_bytes.delete();
        #1;
        chk("arst_load_ready", 32'(load_ready), 32'd0);
        chk("arst_load_done",  32'(load_done),  32'd0);
        chk("arst_overflow",   32'(overflow),   32'd0);
        chk("arst_instr",      instr,           32'd0);
        chk("arst_valid",      32'(instr_valid), 32'd0);
        chk("arst_fault",      32'(fault),      32'd0);
        @(negedge clk); rst_n = 1'b1;
        cycle(0, 1, 8'h11, 1, 32'h0);
        @(posedge clk); #1;
        chk("post_rst_idle_ready", 32'(load_ready), 32'd0);
        chk("post_rst_idle_done",  32'(load_done),  32'd0);
        prog.delete();
        prog.push_back(32'hDEAD_BEEF);
        prog.push_back(HALT);
        load_prog(prog, 0);
        check_status("reload");
        cycle(0, 0, 8'h00, 1, 32'h0);
        cycle(0, 0, 8'h00, 1, 32'h4);
        idle();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_memory.md
# instruction_memory

Instruction-side responder for the MIPS fetch stage: holds the program image and returns the 32-bit instruction at the address presented by the program counter. The image is loaded byte-by-byte from the debug/UART unit through a valid/ready port, assembled big-endian into words, and terminated by the HALT word. Fetches are served only once loading has completed.

## Interface
- NB_ADDR, default `ADDRWIDTH` (32), byte address width of the fetch port
- NB_INSTR, default 32, instruction width
- DEPTH, default 256, memory depth in words (power of two)
- clock_i  in  1  system clock; all state updates on posedge
- reset_i  in  1  asynchronous, active-low reset
- load_start_i  in  1  one-cycle pulse: (re)start image loading at word 0
- load_valid_i  in  1  load_byte_i carries a valid byte
- load_byte_i  in  8  image byte, most significant byte of each word first
- load_ready_o  out  1  byte port ready; byte accepted when valid && ready at posedge
- load_done_o  out  1  image complete, fetch port active
- overflow_o  out  1  memory filled before HALT word was received
- fetch_en_i  in  1  fetch request (stall when 0)
- addr_i  in  NB_ADDR  byte address from the PC
- instr_o  out  NB_INSTR  fetched instruction
- instr_valid_o  out  1  instr_o updated by the previous posedge
- fault_o  out  1  last accepted fetch was invalid; instr_o forced to 0 (NOP)

## Operation
- FSM states: IDLE, LOAD, READY. Reset -> IDLE.
- IDLE: load_ready_o=0, load_done_o=0; load_start_i -> LOAD.
- LOAD: load_ready_o=1. Byte counter (2 bits) and word pointer (log2(DEPTH) bits) start at 0. Each accepted byte shifts into the assembly register; on the 4th byte the assembled word (including the incoming byte) is written to mem[ptr], ptr increments, byte counter wraps to 0.
- HALT word 32'hFFFF_FFFF: stored like any word, then -> READY.
- Word written at ptr = DEPTH-1 that is not HALT: -> READY with overflow_o=1.
- load_start_i in LOAD or READY: restart (ptr=0, byte counter=0, partial word discarded, overflow_o and load_done_o cleared) -> LOAD. load_start_i has priority over a simultaneous byte.
- READY: load_done_o=1, load_ready_o=0. On posedge with fetch_en_i=1: word index = addr_i[log2(DEPTH)+1:2]; if addr_i >= 4*DEPTH then instr_o=0, fault_o=1; else instr_o=mem[index], fault_o=0. instr_valid_o=1.
- fetch_en_i=0 or state != READY: instr_o and fault_o hold, instr_valid_o=0.
- Memory array is not cleared by reset; only control state is.

## Timing
- Reset values: load_ready_o=0, load_done_o=0, overflow_o=0, instr_o=0, instr_valid_o=0, fault_o=0; byte counter, ptr, assembly register=0.
- PC updates addr_i on negedge; block samples it on the following posedge. Fetch latency: 1 posedge.
- Byte throughput: one byte per cycle; word write occurs on the posedge accepting byte 4.
- LOAD -> READY on the posedge writing the HALT/last word; load_done_o high from that edge; first fetch accepted on the next posedge.
- Reset assertion mid-load or mid-fetch: immediate return to IDLE and reset values, no clock required.

## Configuration
- IMEM_ALIGN_CHECK_EN defined: fetch with addr_i[1:0] != 0 yields instr_o=0, fault_o=1 (same as out-of-range).
- Not defined: addr_i[1:0] ignored; only out-of-range sets fault_o.

## Test plan
- Reset then load_start, bytes 20 08 00 05, FF FF FF FF; fetch addr 0 -> instr_o=32'h2008_0005 one posedge later, instr_valid_o=1, load_done_o=1; addr 4 -> 32'hFFFF_FFFF.
- Fetch with fetch_en_i=1 during LOAD -> instr_valid_o=0, instr_o holds 0.
- Load DEPTH=256 non-HALT words -> overflow_o=1, load_done_o=1 after word 255; fetch addr 1020 -> word 255.
- Fetch addr 4*DEPTH=1024 -> instr_o=0, fault_o=1; next fetch addr 0 -> fault_o=0. With IMEM_ALIGN_CHECK_EN, addr 2 -> fault_o=1; without, addr 2 returns word 0.
- Two bytes sent, then load_start_i with simultaneous valid byte -> partial discarded, byte ignored; reload 00 00 00 00, FF FF FF FF -> addr 0 reads 0.
- Assert reset_i low mid-load after 6 bytes -> outputs to reset values asynchronously, state IDLE; load_start_i required to reload.
